prc_event_log: RTL and testbench
================================

Name: prc_event_log

Overview:
- Sits directly downstream of the PRC flag stage and consumes its per-virtual-socket capture pulses and error flags for the shift and count sockets.
- Turns each reconfiguration-complete event into a 32-bit record with socket ID, error bit, sequence number and timestamp, and buffers records in a small FWFT FIFO.
- A valid/ready read port drains the FIFO for software or an ILA/UART dumper.
- Keeps per-socket reconfiguration and error counters plus drop accounting.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- TS_W, 24, timestamp counter width; maximum 24.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- vs_shift_capture  in  1  one-cycle pulse: shift socket reconfiguration done
- vs_count_capture  in  1  one-cycle pulse: count socket reconfiguration done
- vs_shift_err  in  1  shift socket error level
- vs_count_err  in  1  count socket error level
- clr  in  1  synchronous clear pulse
- evt_data  out  32  head record
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer accept
- shift_cnt  out  16  shift reconfigurations, wrapping
- count_cnt  out  16  count reconfigurations, wrapping
- shift_err_cnt  out  8  shift events with err=1, saturating at 255
- count_err_cnt  out  8  count events with err=1, saturating at 255
- drop_cnt  out  8  events lost, saturating at 255
- overflow  out  1  sticky: at least one event lost

Behaviour:
- Reset state: all outputs 0, FIFO empty, pending registers clear, seq 0, timestamp 0.
- Record layout:
  - [31] vs_id: 0 = shift, 1 = count.
  - [30] err: the socket's err input sampled in the capture cycle.
  - [29:24] seq.
  - [23:0] timestamp, zero-extended from TS_W.
- Timestamp: free-running counter, +1 every cycle, wraps at 2^TS_W. The record carries the counter value of the capture cycle, not the commit cycle.
- Seq: 6-bit global counter, wraps 63 -> 0. Every capture consumes one seq value, including dropped events, so gaps show losses.
  - Both captures in the same cycle: shift gets seq, count gets seq+1, seq advances by 2.
- Pending stage: one pending slot per socket holds {err, seq, timestamp}. The FIFO write port commits at most one record per cycle.
  - Priority: pending shift > pending count > new shift > new count.
  - A new capture that cannot commit this cycle goes to its socket's pending slot.
  - If that slot is already occupied, the event is dropped.
- Latency: an uncontended capture in cycle N is written at the end of N; evt_valid is high in N+1. A deferred count record commits in N+1 and is visible in N+2.
- FIFO: first-word-fall-through. evt_data is valid whenever evt_valid=1. Pop occurs on evt_valid & evt_ready. evt_data is don't-care when empty.
  - Full with pop in the same cycle: the write is accepted.
  - Full without pop: the commit candidate is dropped and stays neither in its pending slot nor anywhere else.
  - Empty with evt_ready high: no effect.
- Per-socket counters: shift_cnt/count_cnt increment at capture time, including dropped events. err counters increment when the sampled err=1.
- Drops: each lost event increments drop_cnt, saturating at 255, and sets overflow.
- Clear: clr flushes the FIFO and pending slots and zeroes all counters, drop_cnt, overflow and seq. The timestamp is not cleared. Captures in the clr cycle are discarded without counting.
- Reset mid-operation: immediate return to the reset state. There is no partial record.

Optional Feature:
- Macro: PRC_EVT_TIMESTAMP_EN.
- Defined: timestamp counter present; bits [23:0] as described above.
- Undefined: no timestamp counter is built; bits [23:0] carry the socket's 16-bit reconfiguration count after the increment, zero-extended. Pending slots store that count instead of a timestamp.

Test Plan:
- Single shift capture at cycle 10 with vs_shift_err=0, evt_ready=0 -> evt_valid=1 in cycle 11; evt_data={0,0,seq 0,ts 10}; shift_cnt=1.
- Simultaneous shift and count captures at cycle 20 with vs_count_err=1 -> two records in order: shift (seq n), then count (seq n+1, err=1, ts 20); count_err_cnt=1.
- DEPTH=16, evt_ready=0, 18 shift captures spaced 3 cycles apart -> 16 records held; drop_cnt=2; overflow=1; shift_cnt=18; seq values 16 and 17 never appear.
- FIFO full, evt_ready=1 and a capture in the same cycle -> FIFO stays full; new record accepted; drop_cnt unchanged; the popped head was seq 0.
- Pulse clr with 5 records queued and overflow=1 -> evt_valid=0 next cycle; all counters and overflow 0; the next capture gets seq 0.
- Assert resetn low mid-stream with records queued -> all outputs 0 asynchronously; after release the first capture yields seq 0 and ts equal to the cycles elapsed since release.

Source files
------------

// File: rtl/prc_event_log.sv
// PRC event logger: turns per-socket capture pulses into 32-bit records buffered in a FWFT FIFO.
// Optional macro PRC_EVT_TIMESTAMP_EN selects a timestamp in bits [23:0]; otherwise the socket count is logged there.
module prc_event_log #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vs_shift_capture,
  input  logic        vs_count_capture,
  input  logic        vs_shift_err,
  input  logic        vs_count_err,
  input  logic        clr,
  output logic [31:0] evt_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] shift_cnt,
  output logic [15:0] count_cnt,
  output logic [7:0]  shift_err_cnt,
  output logic [7:0]  count_err_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1 || TS_W > 24) begin : g_param_err
    $error("prc_event_log: DEPTH must be a power of 2 >= 2 and TS_W in 1..24");
  end

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        r_ps_vld;
  logic        r_ps_err;
  logic [5:0]  r_ps_seq;
  logic [23:0] r_ps_low;
  logic        r_pc_vld;
  logic        r_pc_err;
  logic [5:0]  r_pc_seq;
  logic [23:0] r_pc_low;

  logic [5:0]  r_seq;
  logic [15:0] r_shift_cnt;
  logic [15:0] r_count_cnt;
  logic [7:0]  r_shift_err_cnt;
  logic [7:0]  r_count_err_cnt;
  logic [7:0]  r_drop_cnt;
  logic        r_overflow;

  logic        w_cap_s;
  logic        w_cap_c;
  logic [5:0]  w_new_s_seq;
  logic [5:0]  w_new_c_seq;
  logic [23:0] w_new_s_low;
  logic [23:0] w_new_c_low;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_sel_ps;
  logic        w_sel_pc;
  logic        w_sel_ns;
  logic        w_sel_nc;
  logic        w_cand_vld;
  logic [31:0] w_cand_rec;
  logic        w_wr;
  logic        w_cand_drop;
  logic        w_ps_free;
  logic        w_pc_free;
  logic        w_ns_to_pend;
  logic        w_nc_to_pend;
  logic        w_ns_drop;
  logic        w_nc_drop;
  logic [1:0]  w_drop_n;
  logic [8:0]  w_drop_sum;

  // Captures coinciding with clr are discarded entirely.
  assign w_cap_s     = vs_shift_capture & ~clr;
  assign w_cap_c     = vs_count_capture & ~clr;
  assign w_new_s_seq = r_seq;
  assign w_new_c_seq = r_seq + {5'd0, w_cap_s};

`ifdef PRC_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_ts <= '0;
    else         r_ts <= r_ts + 1'b1;
  end

  assign w_new_s_low = 24'(r_ts);
  assign w_new_c_low = 24'(r_ts);
`else
  assign w_new_s_low = {8'd0, r_shift_cnt + 16'd1};
  assign w_new_c_low = {8'd0, r_count_cnt + 16'd1};
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & evt_ready;

  assign w_sel_ps = r_ps_vld;
  assign w_sel_pc = ~r_ps_vld & r_pc_vld;
  assign w_sel_ns = ~r_ps_vld & ~r_pc_vld & w_cap_s;
  assign w_sel_nc = ~r_ps_vld & ~r_pc_vld & ~w_cap_s & w_cap_c;

  assign w_cand_vld = w_sel_ps | w_sel_pc | w_sel_ns | w_sel_nc;

  always_comb begin
    w_cand_rec = {1'b1, vs_count_err, w_new_c_seq, w_new_c_low};
    if (w_sel_ps)      w_cand_rec = {1'b0, r_ps_err, r_ps_seq, r_ps_low};
    else if (w_sel_pc) w_cand_rec = {1'b1, r_pc_err, r_pc_seq, r_pc_low};
    else if (w_sel_ns) w_cand_rec = {1'b0, vs_shift_err, w_new_s_seq, w_new_s_low};
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign w_wr        = w_cand_vld & (~w_full | w_pop) & ~clr;
  assign w_cand_drop = w_cand_vld & ~w_wr & ~clr;

  // A slot whose record leaves this cycle (committed or dropped) can take a new event.
  assign w_ps_free    = ~r_ps_vld | w_sel_ps;
  assign w_pc_free    = ~r_pc_vld | w_sel_pc;
  assign w_ns_to_pend = w_cap_s & ~w_sel_ns & w_ps_free;
  assign w_nc_to_pend = w_cap_c & ~w_sel_nc & w_pc_free;
  assign w_ns_drop    = w_cap_s & ~w_sel_ns & ~w_ps_free;
  assign w_nc_drop    = w_cap_c & ~w_sel_nc & ~w_pc_free;

  assign w_drop_n   = {1'b0, w_cand_drop} + {1'b0, w_ns_drop} + {1'b0, w_nc_drop};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_n};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_cand_rec;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_ps_vld        <= 1'b0;
      r_ps_err        <= 1'b0;
      r_ps_seq        <= '0;
      r_ps_low        <= '0;
      r_pc_vld        <= 1'b0;
      r_pc_err        <= 1'b0;
      r_pc_seq        <= '0;
      r_pc_low        <= '0;
      r_seq           <= '0;
      r_shift_cnt     <= '0;
      r_count_cnt     <= '0;
      r_shift_err_cnt <= '0;
      r_count_err_cnt <= '0;
      r_drop_cnt      <= '0;
      r_overflow      <= 1'b0;
    end else if (clr) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_ps_vld        <= 1'b0;
      r_pc_vld        <= 1'b0;
      r_seq           <= '0;
      r_shift_cnt     <= '0;
      r_count_cnt     <= '0;
      r_shift_err_cnt <= '0;
      r_count_err_cnt <= '0;
      r_drop_cnt      <= '0;
      r_overflow      <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_ns_to_pend) begin
        r_ps_vld <= 1'b1;
        r_ps_err <= vs_shift_err;
        r_ps_seq <= w_new_s_seq;
        r_ps_low <= w_new_s_low;
      end else if (w_sel_ps) begin
        r_ps_vld <= 1'b0;
      end

      if (w_nc_to_pend) begin
        r_pc_vld <= 1'b1;
        r_pc_err <= vs_count_err;
        r_pc_seq <= w_new_c_seq;
        r_pc_low <= w_new_c_low;
      end else if (w_sel_pc) begin
        r_pc_vld <= 1'b0;
      end

      r_seq       <= r_seq + {5'd0, w_cap_s} + {5'd0, w_cap_c};
      r_shift_cnt <= r_shift_cnt + {15'd0, w_cap_s};
      r_count_cnt <= r_count_cnt + {15'd0, w_cap_c};

      if (w_cap_s && vs_shift_err && r_shift_err_cnt != 8'hFF)
        r_shift_err_cnt <= r_shift_err_cnt + 8'd1;
      if (w_cap_c && vs_count_err && r_count_err_cnt != 8'hFF)
        r_count_err_cnt <= r_count_err_cnt + 8'd1;

      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_drop_n != 2'd0) r_overflow <= 1'b1;
    end
  end

  assign evt_valid     = ~w_empty;
  assign evt_data      = w_empty ? 32'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign shift_cnt     = r_shift_cnt;
  assign count_cnt     = r_count_cnt;
  assign shift_err_cnt = r_shift_err_cnt;
  assign count_err_cnt = r_count_err_cnt;
  assign drop_cnt      = r_drop_cnt;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_prc_event_log.sv
// Directed bench for prc_event_log; expected records are built by hand from seq, socket and count/timestamp.
module tb_prc_event_log;

  logic        clk;
  logic        resetn;
  logic        vs_shift_capture;
  logic        vs_count_capture;
  logic        vs_shift_err;
  logic        vs_count_err;
  logic        clr;
  logic [31:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] shift_cnt;
  logic [15:0] count_cnt;
  logic [7:0]  shift_err_cnt;
  logic [7:0]  count_err_cnt;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int n_cmp;
  int n_err;
  int cyc;
  int last_ts;
  logic [31:0] exp_q[$];

  prc_event_log #(.DEPTH(16), .TS_W(24)) u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .vs_shift_capture (vs_shift_capture),
    .vs_count_capture (vs_count_capture),
    .vs_shift_err     (vs_shift_err),
    .vs_count_err     (vs_count_err),
    .clr              (clr),
    .evt_data         (evt_data),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .shift_cnt        (shift_cnt),
    .count_cnt        (count_cnt),
    .shift_err_cnt    (shift_err_cnt),
    .count_err_cnt    (count_err_cnt),
    .drop_cnt         (drop_cnt),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals the timestamp a capture issued now would carry.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  function automatic logic [23:0] exp_low(input logic [15:0] cnt, input int ts);
`ifdef PRC_EVT_TIMESTAMP_EN
    exp_low = 24'(ts) | (24'(cnt) & 24'd0);
`else
    exp_low = {8'd0, cnt} | (24'(ts) & 24'd0);
`endif
  endfunction

  function automatic logic [31:0] rec(input logic id, input logic err, input int seq, input logic [23:0] low);
    logic [5:0] s;
    s = 6'(seq);
    rec = {id, err, s, low};
  endfunction

  task automatic cap(input logic s, input logic c, input logic se, input logic ce);
    vs_shift_capture = s;
    vs_count_capture = c;
    vs_shift_err     = se;
    vs_count_err     = ce;
    last_ts          = cyc;
    @(negedge clk);
    vs_shift_capture = 1'b0;
    vs_count_capture = 1'b0;
    vs_shift_err     = 1'b0;
    vs_count_err     = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 200 && cyc < n; k++) @(negedge clk);
    chk("wait_cyc", 32'(cyc), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0; last_ts = 0;
    resetn = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    vs_shift_capture = 1'b0; vs_count_capture = 1'b0;
    vs_shift_err = 1'b0; vs_count_err = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_data", evt_data, 32'd0);
    chk("rst_shift_cnt", 32'(shift_cnt), 32'd0);
    chk("rst_count_cnt", 32'(count_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Single shift capture at cycle 10
    wait_cyc(10);
    cap(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(evt_valid), 32'd1);
    chk("t1_data", evt_data, rec(1'b0, 1'b0, 0, exp_low(16'd1, 10)));
    chk("t1_shift_cnt", 32'(shift_cnt), 32'd1);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("t1_empty", 32'(evt_valid), 32'd0);

    // Simultaneous captures at cycle 20: shift first, count deferred one cycle
    wait_cyc(20);
    cap(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2_shift_rec", evt_data, rec(1'b0, 1'b0, 1, exp_low(16'd2, 20)));
    chk("t2_count_err_cnt", 32'(count_err_cnt), 32'd1);
    chk("t2_count_cnt", 32'(count_cnt), 32'd1);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("t2_count_valid", 32'(evt_valid), 32'd1);
    chk("t2_count_rec", evt_data, rec(1'b1, 1'b1, 2, exp_low(16'd1, 20)));
    @(negedge clk);
    evt_ready = 1'b0;
    chk("t2_empty", 32'(evt_valid), 32'd0);

    // Fill to overflow: 18 shift captures, 3 cycles apart, no reads
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t3_clr_shift_cnt", 32'(shift_cnt), 32'd0);
    for (int i = 0; i < 18; i++) begin
      cap(1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 16) exp_q.push_back(rec(1'b0, 1'b0, i, exp_low(16'(i + 1), last_ts)));
      @(negedge clk);
      @(negedge clk);
    end
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_shift_cnt", 32'(shift_cnt), 32'd18);
    chk("t3_head", evt_data, exp_q[0]);

    // Full FIFO with pop and capture in the same cycle
    void'(exp_q.pop_front());
    evt_ready = 1'b1;
    cap(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(rec(1'b0, 1'b0, 18, exp_low(16'd19, last_ts)));
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_shift_cnt", 32'(shift_cnt), 32'd19);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4_drain%0d", k), evt_data, exp_q[k]);
      @(negedge clk);
    end
    chk("t4_empty", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Clear with 5 queued records and overflow set; count capture in clr cycle is discarded
    for (int i = 0; i < 5; i++) begin
      cap(1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("t5_ovf_before", 32'(overflow), 32'd1);
    chk("t5_cnt_before", 32'(shift_cnt), 32'd24);
    clr = 1'b1;
    vs_count_capture = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vs_count_capture = 1'b0;
    chk("t5_valid", 32'(evt_valid), 32'd0);
    chk("t5_shift_cnt", 32'(shift_cnt), 32'd0);
    chk("t5_count_cnt", 32'(count_cnt), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_cerr", 32'(count_err_cnt), 32'd0);
    cap(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_rec", evt_data, rec(1'b0, 1'b1, 0, exp_low(16'd1, last_ts)));
    chk("t5_serr", 32'(shift_err_cnt), 32'd1);

    // Asynchronous reset mid-stream
    cap(1'b0, 1'b1, 1'b0, 1'b0);
    cap(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_valid", 32'(evt_valid), 32'd0);
    chk("t6_data", evt_data, 32'd0);
    chk("t6_shift_cnt", 32'(shift_cnt), 32'd0);
    chk("t6_count_cnt", 32'(count_cnt), 32'd0);
    chk("t6_serr", 32'(shift_err_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wait_cyc(5);
    cap(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_valid_after", 32'(evt_valid), 32'd1);
    chk("t6_rec", evt_data, rec(1'b0, 1'b0, 0, exp_low(16'd1, 5)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
